// File: rtl/restador_inverso_if.sv
// Request/result bundle for the bit-serial subtractor inverse.
// The requester drives start and the operand triple; the unit returns status and the rebuilt minuend.
interface restador_inverso_if #(
  parameter int BITS = 4
);
  logic            start;
  logic [BITS-1:0] num2;
  logic [BITS-1:0] res;
  logic            flag;
  logic            busy;
  logic            done;
  logic [BITS-1:0] num1_out;
  logic            invalid;

  modport master (
    output start, num2, res, flag,
    input  busy, done, num1_out, invalid
  );

  modport slave (
    input  start, num2, res, flag,
    output busy, done, num1_out, invalid
  );
endinterface

// File: rtl/restador_inverso.sv
// Rebuilds num1 from (num2, res, flag) as num2 + X + 1, one bit per clock, LSB first.
// done pulses BITS+1 edges after start is accepted; start is ignored while busy.
module restador_inverso #(
  parameter int BITS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  restador_inverso_if.slave  bus
);
  localparam int CW = $clog2(BITS + 1);
  localparam logic [CW-1:0] LAST = CW'(BITS - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e          state_q, state_d;
  logic [BITS-1:0] a_q, a_d;
  logic [BITS-1:0] x_q, x_d;
  logic [BITS-1:0] r_q, r_d;
  logic [BITS-1:0] num1_q, num1_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            c_q, c_d;
  logic            flag_q, flag_d;
  logic            inv_q, inv_d;
  logic            done_q, done_d;
  logic            sum_bit;
  logic            carry_bit;

  // Full adder on the current LSBs; carry starts at 1 to form num2 + X + 1.
  assign sum_bit   = a_q[0] ^ x_q[0] ^ c_q;
  assign carry_bit = (a_q[0] & x_q[0]) | (a_q[0] & c_q) | (x_q[0] & c_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    x_d     = x_q;
    r_d     = r_q;
    num1_d  = num1_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    flag_d  = flag_q;
    inv_d   = inv_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.num2;
          x_d     = bus.flag ? bus.res : ~bus.res;
          flag_d  = bus.flag;
          c_d     = 1'b1;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        r_d   = {sum_bit, r_q[BITS-1:1]};
        c_d   = carry_bit;
        a_d   = {1'b0, a_q[BITS-1:1]};
        x_d   = {1'b0, x_q[BITS-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // Final carry equal to the flag means the triple cannot come from the forward subtractor.
        num1_d  = r_q;
        inv_d   = (c_q == flag_q);
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      x_q     <= '0;
      r_q     <= '0;
      num1_q  <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      flag_q  <= 1'b0;
      inv_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      x_q     <= x_d;
      r_q     <= r_d;
      num1_q  <= num1_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      flag_q  <= flag_d;
      inv_q   <= inv_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.num1_out = num1_q;
  assign bus.invalid  = inv_q;
endmodule
